// File: rtl/nibbler_pkg.sv
// Nibbler shared definitions: program address width and the
// PC operation codes used by the program counter and its bench.
package nibbler_pkg;

    localparam int NIB_ADDR_W = 12;
    localparam int NIB_DEPTH  = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses for CALL/RET.
// Ports: clk, notReset (async, active-low), push/pushData, pop,
// top (newest entry, 0 when empty), full, empty.
module pc_return_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);
    localparam int SLOTS = 1 << IW;

    logic [PW-1:0]     ptr;
    logic [ADDR_W-1:0] mem [SLOTS];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;

    // ptr counts held entries; slot ptr is the next free one.
    assign wr_idx = IW'(ptr);
    assign rd_idx = IW'(ptr - PW'(1));

    assign empty = (ptr == '0);
    assign full  = (ptr == PW'(DEPTH));
    assign top   = empty ? '0 : mem[rd_idx];

    // Overflowing pushes and underflowing pops are dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            ptr <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_idx] <= pushData;
            ptr         <= ptr + PW'(1);
        end else if (do_pop) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Nibbler program counter with return-address stack.
// Ports: clk, notReset, enable, notLoadPC, call, ret, loadAddress,
// clrErr -> address, stackEmpty, stackFull, overflowErr, underflowErr.
module pc_call_stack
    import nibbler_pkg::*;
#(
    parameter int                ADDR_W     = NIB_ADDR_W,
    parameter int                DEPTH      = NIB_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              enable,
    input  logic              notLoadPC,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] loadAddress,
    input  logic              clrErr,
    output logic [ADDR_W-1:0] address,
    output logic              stackEmpty,
    output logic              stackFull,
    output logic              overflowErr,
    output logic              underflowErr
);

    pc_op_e            op;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_push;
    logic              stk_pop;
    logic              ovf_evt;
    logic              unf_evt;

    assign addr_inc = address + ADDR_W'(1);

    // Fixed priority call > ret > load > increment, written as
    // disjoint terms. A ret on an empty stack degrades to increment.
    always_comb begin
        op = PC_HOLD;
        unique case (1'b1)
            !enable: op = PC_HOLD;
            enable && call: op = PC_CALL;
            enable && !call && ret && !stackEmpty: op = PC_RET;
            enable && !call && ret && stackEmpty: op = PC_INC;
            enable && !call && !ret && !notLoadPC: op = PC_LOAD;
            default: op = PC_INC;
        endcase
    end

    always_comb begin
        addr_nxt = address;
        unique case (op)
            PC_CALL: addr_nxt = loadAddress;
            PC_LOAD: addr_nxt = loadAddress;
            PC_RET:  addr_nxt = stk_top;
            PC_INC:  addr_nxt = addr_inc;
            default: addr_nxt = address;
        endcase
    end

    assign ovf_evt  = enable && call && stackFull;
    assign unf_evt  = enable && !call && ret && stackEmpty;

    // The stack itself drops the push when full.
    assign stk_push = (op == PC_CALL);
    assign stk_pop  = (op == PC_RET);

    pc_return_stack #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_stack (
        .clk     (clk),
        .notReset(notReset),
        .push    (stk_push),
        .pop     (stk_pop),
        .pushData(addr_inc),
        .top     (stk_top),
        .full    (stackFull),
        .empty   (stackEmpty)
    );

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            address <= RESET_ADDR;
        end else begin
            address <= addr_nxt;
        end
    end

    // Error flags: a new event beats a clear in the same cycle.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            overflowErr  <= 1'b0;
            underflowErr <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflowErr <= 1'b1;
            end else if (clrErr) begin
                overflowErr <= 1'b0;
            end
            if (unf_evt) begin
                underflowErr <= 1'b1;
            end else if (clrErr) begin
                underflowErr <= 1'b0;
            end
        end
    end

endmodule
